calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Parametrised keypad-to-result controller for the calculator datapath. It takes debounced single-cycle key events, accumulates decimal operands of up to `DIGITS` digits, and sequences add/subtract operations, including chained operations and a sticky overflow error. It sits between the keypad decoder and the display driver and contains its own arithmetic unit.

## Interface
- `DIGITS`, default 4: maximum decimal digits per operand and per result magnitude.
- `W`, default derived as ceil(log2(10^DIGITS)), 14 for the default: magnitude width. Treat it as a localparam and do not override it.
- `clk`, input, 1: the single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `key_valid`, input, 1: one-cycle pulse meaning `key_code` is valid. Pulses are already synchronised upstream.
- `key_code`, input, 4: key identity. 0–9 are digits, 0xA is plus, 0xB is minus, 0xC is equals, 0xD is clear. 0xE and 0xF are ignored.
- `disp_mag`, output, W: magnitude of the value currently shown.
- `disp_neg`, output, 1: sign of the value shown.
- `err`, output, 1: sticky overflow flag.
- `state_dbg`, output, 3: current state encoding, for debug.
- `digit_cnt`, output, ceil(log2(DIGITS+1)): number of digits entered into the active operand.

## Operation
- Internal values are two's complement, W+2 bits. Registers: `acc_a`, `acc_b`, `op` (plus or minus), `res`.
- Digit entry: `operand <= operand*10 + digit` while `digit_cnt < DIGITS`. Further digits are ignored. Leading zeros count as digits.
- States: `IDLE`, `ENTER_A`, `OP_WAIT`, `ENTER_B`, `RESULT`, `ERROR`.
- Clear in any state does three things:
  - go to `IDLE`;
  - zero all registers;
  - clear `err`.
- `IDLE`:
  - Digit: go to `ENTER_A` with A equal to that digit.
  - Operator: latch `op` with A=0 and go to `OP_WAIT`.
  - Equals: ignored.
- `ENTER_A`:
  - Digit: accumulate.
  - Operator: latch `op` and go to `OP_WAIT`.
  - Equals: ignored.
- `OP_WAIT`:
  - Operator: replaces `op`.
  - Digit: go to `ENTER_B` with B equal to that digit and `digit_cnt` = 1.
  - Equals: ignored.
- `ENTER_B`:
  - Digit: accumulate.
  - Equals: compute `res = A op B` and go to `RESULT`.
  - Operator (chaining): compute `res`, load A with `res`, latch the new `op`, and go to `OP_WAIT`.
- `RESULT`:
  - Digit: start a fresh A and go to `ENTER_A`.
  - Operator: load A with `res`, latch `op`, and go to `OP_WAIT`.
  - Equals: ignored. There is no repeat-last-operation.
- Overflow check on every compute: |res| > 10^DIGITS − 1. On overflow, set `err` = 1 and go to `ERROR`. In `ERROR`, only clear or reset has any effect.
- Display source by state:
  - `IDLE`: 0.
  - `ENTER_A`: A.
  - `OP_WAIT`: A.
  - `ENTER_B`: B.
  - `RESULT`: `res`.
  - `ERROR`: `disp_mag` = 0 and `disp_neg` = 0.
- `disp_neg` is asserted only for a nonzero negative value. `disp_mag` is the absolute value, truncated to W bits.

## Timing
- Reset values: state `IDLE`, all registers 0, `disp_mag` = 0, `disp_neg` = 0, `err` = 0, `digit_cnt` = 0, `state_dbg` = `IDLE`.
- Outputs are registered. A key accepted at edge n is visible on all outputs after edge n+1, a latency of one cycle. Computation completes in the same cycle.
- A `key_valid` pulse in back-to-back cycles must be processed on every cycle. There is no busy or backpressure.
- Asserting reset mid-operation clears everything immediately and asynchronously. Deassertion is synchronised by the parent.
- Clear and `key_valid` share the key path, so they cannot collide.

## Structure
- A shared package, `calc_pkg`, holds:
  - the key-code constants (`KEY_PLUS`, `KEY_MINUS`, `KEY_EQ`, `KEY_CLR`);
  - the state enum;
  - the op enum (`OP_ADD`, `OP_SUB`).
- One sub-module, `calc_alu`: combinational, parametrised by `DIGITS`. Inputs are a, b and op. Outputs are the W+2-bit result and an `ovf` flag.
- The FSM, the digit accumulators and the display mux stay in `calc_sequencer`.

## Test plan
All scenarios use `DIGITS`=4.
- Keys 1, 2, +, 3, 4, = → `disp_mag`=46, `disp_neg`=0, final state `RESULT`.
- Keys 5, −, 9, = → `disp_mag`=4, `disp_neg`=1.
- Keys 2, +, 3, +, 4, =:
  - after the second + → `disp_mag`=5, state `OP_WAIT`;
  - after = → `disp_mag`=9.
- Keys 9, 9, 9, 9, +, 1, = → `err`=1, state `ERROR`, `disp_mag`=0. A following digit 7 is ignored. Clear then returns `err`=0 and state `IDLE`.
- Keys 1, 2, 3, 4, 5 → `disp_mag`=1234 and `digit_cnt`=4. The same keys sent on consecutive cycles give the same result.
- Keys 1, +, 2, then reset asserted between the 2 and the = → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared key codes, FSM states and operator encoding for the
//            calculator sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

   localparam logic [3:0] KEY_PLUS  = 4'hA;
   localparam logic [3:0] KEY_MINUS = 4'hB;
   localparam logic [3:0] KEY_EQ    = 4'hC;
   localparam logic [3:0] KEY_CLR   = 4'hD;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTER_A = 3'd1,
      OP_WAIT = 3'd2,
      ENTER_B = 3'd3,
      RESULT  = 3'd4,
      ERROR   = 3'd5
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_PLUS) || (k == KEY_MINUS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu
// Brief    : Combinational add/subtract on W+2-bit two's complement operands
//            with a decimal-magnitude overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module calc_alu
   import calc_pkg::*;
#(
   parameter  int DIGITS = 4,
   localparam int W      = $clog2(10**DIGITS)
) (
   input  logic signed [W+1:0] a,
   input  logic signed [W+1:0] b,
   input  op_t                 op,
   output logic signed [W+1:0] res,
   output logic                ovf
);

   localparam logic signed [W+1:0] c_MAX_MAG = (W+2)'(10**DIGITS - 1);

   logic signed [W+1:0] w_abs;

   always_comb begin
      res   = (op == OP_SUB) ? (a - b) : (a + b);
      w_abs = (res < 0) ? -res : res;
      ovf   = (w_abs > c_MAX_MAG);
   end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Keypad-to-result controller: operand entry, add/subtract
//            sequencing with chaining, sticky overflow and registered display.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer
   import calc_pkg::*;
#(
   parameter  int DIGITS = 4,
   localparam int W      = $clog2(10**DIGITS),
   localparam int CW     = $clog2(DIGITS+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          key_valid,
   input  logic [3:0]    key_code,
   output logic [W-1:0]  disp_mag,
   output logic          disp_neg,
   output logic          err,
   output logic [2:0]    state_dbg,
   output logic [CW-1:0] digit_cnt
);

   localparam logic signed [W+1:0] c_TEN        = (W+2)'(10);
   localparam logic [CW-1:0]       c_MAX_DIGITS = CW'(DIGITS);

   state_t              r_state, w_state_nxt;
   op_t                 r_op, w_op_nxt, w_key_op;
   logic signed [W+1:0] r_acc_a, w_acc_a_nxt;
   logic signed [W+1:0] r_acc_b, w_acc_b_nxt;
   logic signed [W+1:0] r_res, w_res_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic                r_err, w_err_nxt;

   logic signed [W+1:0] w_digit, w_alu_res, w_disp_val, w_disp_abs;
   logic                w_alu_ovf, w_room;

   assign w_digit  = {{(W-2){1'b0}}, key_code};
   assign w_key_op = (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
   assign w_room   = (r_cnt < c_MAX_DIGITS);

   calc_alu #(.DIGITS(DIGITS)) u_alu (
      .a   (r_acc_a),
      .b   (r_acc_b),
      .op  (r_op),
      .res (w_alu_res),
      .ovf (w_alu_ovf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_op    <= OP_ADD;
         r_acc_a <= '0;
         r_acc_b <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_acc_a <= w_acc_a_nxt;
         r_acc_b <= w_acc_b_nxt;
         r_res   <= w_res_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_acc_a_nxt = r_acc_a;
      w_acc_b_nxt = r_acc_b;
      w_res_nxt   = r_res;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      if (key_valid) begin
         if (key_code == KEY_CLR) begin
            w_state_nxt = IDLE;
            w_op_nxt    = OP_ADD;
            w_acc_a_nxt = '0;
            w_acc_b_nxt = '0;
            w_res_nxt   = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
         end else begin
            case (r_state)
               IDLE, RESULT: begin
                  if (is_digit(key_code)) begin
                     w_acc_a_nxt = w_digit;
                     w_cnt_nxt   = CW'(1);
                     w_state_nxt = ENTER_A;
                  end else if (is_op(key_code)) begin
                     // From RESULT the previous answer becomes the new left operand
                     w_acc_a_nxt = (r_state == RESULT) ? r_res : '0;
                     w_op_nxt    = w_key_op;
                     w_cnt_nxt   = '0;
                     w_state_nxt = OP_WAIT;
                  end
               end
               ENTER_A: begin
                  if (is_digit(key_code) && w_room) begin
                     w_acc_a_nxt = r_acc_a * c_TEN + w_digit;
                     w_cnt_nxt   = r_cnt + CW'(1);
                  end else if (is_op(key_code)) begin
                     w_op_nxt    = w_key_op;
                     w_cnt_nxt   = '0;
                     w_state_nxt = OP_WAIT;
                  end
               end
               OP_WAIT: begin
                  if (is_op(key_code)) begin
                     w_op_nxt = w_key_op;
                  end else if (is_digit(key_code)) begin
                     w_acc_b_nxt = w_digit;
                     w_cnt_nxt   = CW'(1);
                     w_state_nxt = ENTER_B;
                  end
               end
               ENTER_B: begin
                  if (is_digit(key_code) && w_room) begin
                     w_acc_b_nxt = r_acc_b * c_TEN + w_digit;
                     w_cnt_nxt   = r_cnt + CW'(1);
                  end else if (is_op(key_code) || key_code == KEY_EQ) begin
                     w_cnt_nxt = '0;
                     if (w_alu_ovf) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ERROR;
                     end else if (key_code == KEY_EQ) begin
                        w_res_nxt   = w_alu_res;
                        w_state_nxt = RESULT;
                     end else begin
                        w_res_nxt   = w_alu_res;
                        w_acc_a_nxt = w_alu_res;
                        w_op_nxt    = w_key_op;
                        w_state_nxt = OP_WAIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      case (r_state)
         ENTER_A, OP_WAIT: w_disp_val = r_acc_a;
         ENTER_B:          w_disp_val = r_acc_b;
         RESULT:           w_disp_val = r_res;
         default:          w_disp_val = '0;
      endcase
      w_disp_abs = (w_disp_val < 0) ? -w_disp_val : w_disp_val;
   end

   // Output stage: every visible signal is a register copy of the internal state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_mag  <= '0;
         disp_neg  <= 1'b0;
         err       <= 1'b0;
         state_dbg <= IDLE;
         digit_cnt <= '0;
      end else begin
         disp_mag  <= w_disp_abs[W-1:0];
         disp_neg  <= (w_disp_val < 0);
         err       <= r_err;
         state_dbg <= r_state;
         digit_cnt <= r_cnt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Directed self-checking bench for calc_sequencer (DIGITS = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

   localparam int DIGITS = 4;

   localparam logic [31:0] S_IDLE    = 32'd0;
   localparam logic [31:0] S_ENTER_A = 32'd1;
   localparam logic [31:0] S_OP_WAIT = 32'd2;
   localparam logic [31:0] S_ENTER_B = 32'd3;
   localparam logic [31:0] S_RESULT  = 32'd4;
   localparam logic [31:0] S_ERROR   = 32'd5;

   localparam logic [3:0] K_PLUS  = 4'hA;
   localparam logic [3:0] K_MINUS = 4'hB;
   localparam logic [3:0] K_EQ    = 4'hC;
   localparam logic [3:0] K_CLR   = 4'hD;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [13:0] disp_mag;
   logic        disp_neg;
   logic        err;
   logic [2:0]  state_dbg;
   logic [2:0]  digit_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   calc_sequencer #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key_code  (key_code),
      .disp_mag  (disp_mag),
      .disp_neg  (disp_neg),
      .err       (err),
      .state_dbg (state_dbg),
      .digit_cnt (digit_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // Reset held low: outputs at reset values
      repeat (2) @(negedge clk);
      check("rst_mag",   32'(disp_mag),  0);
      check("rst_neg",   32'(disp_neg),  0);
      check("rst_err",   32'(err),       0);
      check("rst_state", 32'(state_dbg), S_IDLE);
      check("rst_cnt",   32'(digit_cnt), 0);
      reset = 1'b1;

      // Equals in IDLE is ignored
      press(K_EQ); settle();
      check("idle_eq_state", 32'(state_dbg), S_IDLE);

      // 12 + 34 = 46
      press(4'd1); press(4'd2); settle();
      check("a12_mag",   32'(disp_mag),  12);
      check("a12_cnt",   32'(digit_cnt), 2);
      check("a12_state", 32'(state_dbg), S_ENTER_A);
      press(K_PLUS); press(4'd3); press(4'd4); press(K_EQ); settle();
      check("add_mag",   32'(disp_mag),  46);
      check("add_neg",   32'(disp_neg),  0);
      check("add_state", 32'(state_dbg), S_RESULT);

      // 5 - 9 = -4
      press(K_CLR);
      press(4'd5); press(K_MINUS); press(4'd9); press(K_EQ); settle();
      check("sub_mag", 32'(disp_mag), 4);
      check("sub_neg", 32'(disp_neg), 1);

      // 2 + 3 + 4 = 9 with chaining
      press(K_CLR);
      press(4'd2); press(K_PLUS); press(4'd3); press(K_PLUS); settle();
      check("chain_mag",   32'(disp_mag),  5);
      check("chain_state", 32'(state_dbg), S_OP_WAIT);
      press(4'd4); press(K_EQ); settle();
      check("chain_res", 32'(disp_mag), 9);

      // 9999 + 1 overflows
      press(K_CLR);
      press(4'd9); press(4'd9); press(4'd9); press(4'd9);
      press(K_PLUS); press(4'd1); press(K_EQ); settle();
      check("ovf_err",   32'(err),       1);
      check("ovf_state", 32'(state_dbg), S_ERROR);
      check("ovf_mag",   32'(disp_mag),  0);
      press(4'd7); settle();
      check("err_dig_state", 32'(state_dbg), S_ERROR);
      check("err_dig_err",   32'(err),       1);
      check("err_dig_mag",   32'(disp_mag),  0);
      press(K_CLR); settle();
      check("clr_err",   32'(err),       0);
      check("clr_state", 32'(state_dbg), S_IDLE);

      // Fifth digit ignored
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); settle();
      check("lim_mag", 32'(disp_mag),  1234);
      check("lim_cnt", 32'(digit_cnt), 4);

      // Same keys back-to-back
      press(K_CLR);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         key_valid = 1'b1;
         key_code  = 4'(i);
      end
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
      settle();
      check("b2b_mag", 32'(disp_mag),  1234);
      check("b2b_cnt", 32'(digit_cnt), 4);

      // Async reset between the 2 and the equals
      press(K_CLR);
      press(4'd1); press(K_PLUS); press(4'd2); settle();
      check("pre_rst_mag",   32'(disp_mag),  2);
      check("pre_rst_state", 32'(state_dbg), S_ENTER_B);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("async_mag",   32'(disp_mag),  0);
      check("async_neg",   32'(disp_neg),  0);
      check("async_err",   32'(err),       0);
      check("async_state", 32'(state_dbg), S_IDLE);
      check("async_cnt",   32'(digit_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      press(K_EQ); settle();
      check("post_rst_state", 32'(state_dbg), S_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
